// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with a one-word holding buffer for gapless streaming
module piso_serializer #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              par_valid_i,
  input  logic [DATA_W-1:0] par_data_i,
  output logic              par_ready_o,
  input  logic              ser_ready_i,
  output logic              serial_o,
  output logic              valid_o,
  output logic              first_o,
  output logic              last_o,
  output logic              empty_o
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  logic [DATA_W-1:0] sr_q, sr_d, hb_q, hb_d, sr_shift;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d, hb_full_q, hb_full_d;
  logic              accept, consume, done;
  assign par_ready_o = !hb_full_q && !reset;
  assign accept      = par_valid_i && par_ready_o;
  assign consume     = busy_q && ser_ready_i;
  assign done        = consume && cnt_q == LAST;
  assign sr_shift    = LSB_FIRST ? {1'b0, sr_q[DATA_W-1:1]} : {sr_q[DATA_W-2:0], 1'b0};
  assign valid_o     = busy_q;
  assign serial_o    = busy_q && (LSB_FIRST ? sr_q[0] : sr_q[DATA_W-1]);
  assign first_o     = busy_q && cnt_q == '0;
  assign last_o      = busy_q && cnt_q == LAST;
  assign empty_o     = !busy_q && !hb_full_q;
  // Next state: idle loads straight into SR; the last bit hands over to HB or a same-cycle word; otherwise shift and buffer
  always_comb begin
    sr_d      = sr_q;
    hb_d      = hb_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hb_full_d = hb_full_q;
    if (!busy_q) begin
      if (accept) begin
        sr_d   = par_data_i;
        cnt_d  = '0;
        busy_d = 1'b1;
      end
    end else if (done) begin
      cnt_d = '0;
      if (hb_full_q) begin
        sr_d      = hb_q;
        hb_full_d = 1'b0;
      end else if (accept) begin
        sr_d = par_data_i;
      end else begin
        sr_d   = sr_shift;
        busy_d = 1'b0;
      end
    end else begin
      if (consume) begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 1'b1;
      end
      if (accept) begin
        hb_d      = par_data_i;
        hb_full_d = 1'b1;
      end
    end
  end
  // State registers; reset discards any partial word immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q      <= '0;
      hb_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hb_full_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      hb_q      <= hb_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hb_full_q <= hb_full_d;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for LSB-first and MSB-first serializer instances
module tb_piso_serializer;
  logic       clk = 1'b0, reset = 1'b1, par_valid_i = 1'b0, ser_ready_i = 1'b1;
  logic [7:0] par_data_i = 8'h00;
  logic       ready_l, serial_l, valid_l, first_l, last_l, empty_l;
  logic       ready_m, serial_m, valid_m, first_m, last_m, empty_m;
  logic [2:0] ql[$], qm[$];
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .reset(reset), .par_valid_i(par_valid_i), .par_data_i(par_data_i),
    .par_ready_o(ready_l), .ser_ready_i(ser_ready_i), .serial_o(serial_l),
    .valid_o(valid_l), .first_o(first_l), .last_o(last_l), .empty_o(empty_l));
  piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .par_valid_i(par_valid_i), .par_data_i(par_data_i),
    .par_ready_o(ready_m), .ser_ready_i(ser_ready_i), .serial_o(serial_m),
    .valid_o(valid_m), .first_o(first_m), .last_o(last_m), .empty_o(empty_m));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      ql.push_back({i == 0, i == 7, w[i]});
      qm.push_back({i == 0, i == 7, w[7-i]});
    end
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset) begin
        checks++;
        if (valid_l !== (ql.size() != 0) || valid_m !== (qm.size() != 0)) begin
          errors++;
          $display("FAIL sb_valid: valid_l=%b valid_m=%b expected %b/%b", valid_l, valid_m, ql.size() != 0, qm.size() != 0);
        end
        if (valid_l && ql.size() != 0) begin
          checks++;
          if ({first_l, last_l, serial_l} !== ql[0]) begin
            errors++;
            $display("FAIL sb_lsb: {first,last,bit}=%b expected %b", {first_l, last_l, serial_l}, ql[0]);
          end
          if (ser_ready_i) void'(ql.pop_front());
        end
        if (valid_m && qm.size() != 0) begin
          checks++;
          if ({first_m, last_m, serial_m} !== qm[0]) begin
            errors++;
            $display("FAIL sb_msb: {first,last,bit}=%b expected %b", {first_m, last_m, serial_m}, qm[0]);
          end
          if (ser_ready_i) void'(qm.pop_front());
        end
        if (par_valid_i && ready_l) push_word(par_data_i);
      end
    end
  endtask
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (empty_l && empty_m && ql.size() == 0 && qm.size() == 0) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({serial_l, valid_l, first_l, last_l, empty_l, ready_l} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_out: {ser,val,first,last,empty,ready}=%b expected 000010", {serial_l, valid_l, first_l, last_l, empty_l, ready_l});
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (ready_l !== 1'b1 || empty_l !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ready=%b empty=%b expected 1 1", ready_l, empty_l);
    end
    tick();
  endtask
  task automatic test_lsb_msb();
    logic [7:0] seq_l = 8'h1E, seq_m = 8'h78;
    par_data_i  = 8'h1E;
    par_valid_i = 1'b1;
    tick();
    par_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (valid_l !== 1'b1 || serial_l !== seq_l[i] || serial_m !== seq_m[i] || first_l !== (i == 0) || last_l !== (i == 7)) begin
        errors++;
        $display("FAIL word_1e bit%0d: v=%b l=%b m=%b f=%b la=%b expected 1 %b %b %b %b", i, valid_l, serial_l, serial_m, first_l, last_l, seq_l[i], seq_m[i], i == 0, i == 7);
      end
      tick();
    end
    checks++;
    if (empty_l !== 1'b1 || valid_l !== 1'b0 || empty_m !== 1'b1) begin
      errors++;
      $display("FAIL word_1e_empty: empty=%b valid=%b empty_m=%b expected 1 0 1", empty_l, valid_l, empty_m);
    end
  endtask
  task automatic test_back_to_back();
    par_data_i  = 8'h0F;
    par_valid_i = 1'b1;
    tick();
    checks++;
    if (valid_l !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: valid=%b expected 1", valid_l);
    end
    par_data_i = 8'hF0;
    tick();
    par_valid_i = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      checks++;
      if (valid_l !== 1'b1 || ready_l !== (k >= 9)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: valid=%b ready=%b expected 1 %b", k, valid_l, ready_l, k >= 9);
      end
      tick();
    end
    checks++;
    if (valid_l !== 1'b0 || empty_l !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: valid=%b empty=%b expected 0 1", valid_l, empty_l);
    end
  endtask
  task automatic test_stall();
    int n = 0;
    bit ok;
    par_data_i  = 8'h1E;
    par_valid_i = 1'b1;
    tick();
    par_valid_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      ser_ready_i = !(c >= 4 && c <= 6);
      if (c >= 4 && c <= 8) begin
        checks++;
        if (serial_l !== 1'b1 || valid_l !== 1'b1 || first_l !== 1'b0 || last_l !== 1'b0) begin
          errors++;
          $display("FAIL stall_c%0d: ser=%b val=%b first=%b last=%b expected 1 1 0 0", c, serial_l, valid_l, first_l, last_l);
        end
      end
      if (valid_l && ser_ready_i) n++;
      tick();
    end
    ser_ready_i = 1'b1;
    wait_idle(ok);
    checks++;
    if (n != 8 || !ok) begin
      errors++;
      $display("FAIL stall_total: bits=%0d idle=%b expected 8 1", n, ok);
    end
  endtask
  task automatic test_third_word();
    int acc = -1;
    bit ok;
    par_data_i  = 8'h0F;
    par_valid_i = 1'b1;
    tick();
    par_data_i = 8'hF0;
    tick();
    par_data_i = 8'h55;
    for (int c = 2; c <= 12; c++) begin
      if (acc < 0) begin
        checks++;
        if (ready_l !== (c >= 9)) begin
          errors++;
          $display("FAIL third_ready_c%0d: ready=%b expected %b", c, ready_l, c >= 9);
        end
        if (ready_l) acc = c;
      end
      tick();
      if (acc >= 0) par_valid_i = 1'b0;
    end
    par_valid_i = 1'b0;
    wait_idle(ok);
    checks++;
    if (acc != 9 || !ok) begin
      errors++;
      $display("FAIL third_accept: cycle=%0d idle=%b expected 9 1", acc, ok);
    end
  endtask
  task automatic test_reset_mid();
    logic [7:0] seq = 8'h81;
    bit ok;
    par_data_i  = 8'h1E;
    par_valid_i = 1'b1;
    tick();
    par_valid_i = 1'b0;
    tick();
    tick();
    checks++;
    if (serial_l !== 1'b1 || valid_l !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: ser=%b val=%b expected 1 1", serial_l, valid_l);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({serial_l, valid_l, first_l, last_l, empty_l, ready_l, valid_m, empty_m} !== 8'b00001001) begin
      errors++;
      $display("FAIL rst_mid: {ser,val,first,last,empty,ready,val_m,empty_m}=%b expected 00001001", {serial_l, valid_l, first_l, last_l, empty_l, ready_l, valid_m, empty_m});
    end
    ql.delete();
    qm.delete();
    #1;
    reset       = 1'b0;
    par_data_i  = 8'h81;
    par_valid_i = 1'b1;
    tick();
    par_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (valid_l !== 1'b1 || serial_l !== seq[i] || serial_m !== seq[7-i]) begin
        errors++;
        $display("FAIL rst_81 bit%0d: v=%b l=%b m=%b expected 1 %b %b", i, valid_l, serial_l, serial_m, seq[i], seq[7-i]);
      end
      tick();
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_81_idle: idle=%b expected 1", ok);
    end
  endtask
  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_lsb_msb();
    test_back_to_back();
    test_stall();
    test_third_word();
    test_reset_mid();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning parallel word width in bits; legal range 2..64.
REQ-002 SHALL have parameter LSB_FIRST, default 1, meaning 1 = bit 0 shifted out first and 0 = bit DATA_W-1 shifted out first.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port par_valid_i  input  1  meaning a parallel word is offered.
REQ-006 SHALL have port par_data_i  input  DATA_W  meaning the offered parallel word.
REQ-007 SHALL have port par_ready_o  output  1  meaning the block can accept a word this cycle.
REQ-008 SHALL have port ser_ready_i  input  1  meaning downstream consumes the current serial bit this cycle.
REQ-009 SHALL have port serial_o  output  1  meaning the current serial bit.
REQ-010 SHALL have port valid_o  output  1  meaning serial_o carries a valid bit.
REQ-011 SHALL have port first_o  output  1  meaning the current bit is the first bit of a word.
REQ-012 SHALL have port last_o  output  1  meaning the current bit is the last bit of a word.
REQ-013 SHALL have port empty_o  output  1  meaning the shift register and the holding buffer are both empty.

Function
REQ-014 SHALL hold state: shift register SR (DATA_W), bit counter CNT ($clog2(DATA_W)), busy flag BUSY, holding buffer HB (DATA_W), and flag HB_FULL.
REQ-015 SHALL accept a word when par_valid_i && par_ready_o; par_ready_o = !HB_FULL && !reset.
REQ-016 SHALL, on acceptance with BUSY=0, load par_data_i into SR, set CNT=0 and BUSY=1; valid_o rises the next cycle (latency 1).
REQ-017 SHALL, on acceptance with BUSY=1, store par_data_i in HB and set HB_FULL=1.
REQ-018 SHALL drive valid_o=BUSY; serial_o=(LSB_FIRST ? SR[0] : SR[DATA_W-1]) when BUSY, else 0.
REQ-019 SHALL drive first_o=BUSY && CNT==0 and last_o=BUSY && CNT==DATA_W-1.
REQ-020 SHALL consume a bit when valid_o && ser_ready_i: shift SR one position toward the output end and increment CNT.
REQ-021 SHALL hold SR, CNT and all outputs unchanged while valid_o && !ser_ready_i.
REQ-022 SHALL, when the last bit is consumed and HB_FULL=1, load HB into SR, set CNT=0, clear HB_FULL, and keep BUSY=1, so the next word's first bit follows with no idle cycle.
REQ-023 SHALL, when the last bit is consumed, HB_FULL=0 and a word is accepted in the same cycle, load that word directly into SR, set CNT=0, and keep BUSY=1.
REQ-024 SHALL, when the last bit is consumed, HB_FULL=0 and no word is accepted, clear BUSY and CNT.
REQ-025 SHALL maintain the invariant HB_FULL implies BUSY.
REQ-026 SHALL drive empty_o=!BUSY && !HB_FULL.
REQ-027 SHALL drop a word offered while par_ready_o=0 without corrupting state; the upstream must hold it.
REQ-028 SHALL shift zeros into the vacated SR position.

Reset
REQ-029 SHALL, on reset assertion, immediately and asynchronously clear SR, HB, CNT, BUSY and HB_FULL, including mid-word; the partial word is discarded.
REQ-030 SHALL, while reset is high, output serial_o=0, valid_o=0, first_o=0, last_o=0, empty_o=1 and par_ready_o=0.
REQ-031 SHALL accept a word on the first rising edge after reset deasserts if par_valid_i=1.

Verification
REQ-032 SHALL verify: DATA_W=8, LSB_FIRST=1, word 0x1E, ser_ready_i=1 -> serial_o 0,1,1,1,1,0,0,0 on 8 consecutive valid cycles starting 1 cycle after acceptance; first_o on bit 1, last_o on bit 8; then empty_o=1.
REQ-033 SHALL verify: LSB_FIRST=0, word 0x1E -> serial_o 0,0,0,1,1,1,1,0.
REQ-034 SHALL verify: back-to-back words 0x0F and 0xF0 -> 16 consecutive valid_o cycles with no gap; par_ready_o=0 while 0xF0 sits in HB.
REQ-035 SHALL verify: ser_ready_i low for 3 cycles at bit 4 of 0x1E -> serial_o held at 1, CNT held; stream resumes with bit 5=1 and still totals 8 bits.
REQ-036 SHALL verify: third word 0x55 offered while HB_FULL -> not accepted until the cycle after the current word's last bit is consumed, then serialized intact.
REQ-037 SHALL verify: reset pulsed at bit 3 of 0x1E -> valid_o=0 and empty_o=1 in the same cycle; the next word 0x81 serializes as 1,0,0,0,0,0,0,1.
